id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register: consumer of the register-file read ports RD1/RD2.

---
 rtl/riscv_pipe_pkg.sv | 15 +
 rtl/id_ex_stage_if.sv | 49 ++++
 rtl/id_bypass_mux.sv | 25 ++
 rtl/id_ex_stage.sv | 87 ++++++++
 tb/tb_id_ex_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants: default widths, control-bundle bit positions,
// the NOP control word and the x0 register index.
package riscv_pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    localparam int MEMRD_BIT = 4;
    localparam int REGWR_BIT = 5;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;
    localparam logic [4:0]            REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between the decode side (ID fields, regfile read data, writeback)
// and the ID/EX pipeline register (stall and EX outputs).
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   rf_rd1;
    logic [XLEN-1:0]   rf_rd2;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_wd;
    logic              flush;
    logic              ex_ready;

    logic              stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
               rf_rd1, rf_rd2, wb_we, wb_rd, wb_wd, flush, ex_ready,
        input  stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_op1, ex_op2, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
               rf_rd1, rf_rd2, wb_we, wb_rd, wb_wd, flush, ex_ready,
        output stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_op1, ex_op2, ex_ctrl, bubble_cnt
    );

endinterface

// File: rtl/id_bypass_mux.sv
// Selects writeback data over register-file data when the same-cycle write
// targets the register being read; x0 always reads as zero.
module id_bypass_mux
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = rf_data;
        if (rs == REG_ZERO) begin
            data = '0;
        end else if (wb_we && (wb_rd == rs)) begin
            data = wb_wd;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush, EX back-pressure hold and a saturating bubble counter.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    logic [XLEN-1:0] byp1;
    logic [XLEN-1:0] byp2;
    logic [XLEN-1:0] ref1;
    logic [XLEN-1:0] ref2;
    logic            lu;
    logic            hold;

    id_bypass_mux #(.XLEN(XLEN)) u_byp1 (
        .rs(bus.id_rs1), .rf_data(bus.rf_rd1),
        .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_wd(bus.wb_wd), .data(byp1)
    );

    id_bypass_mux #(.XLEN(XLEN)) u_byp2 (
        .rs(bus.id_rs2), .rf_data(bus.rf_rd2),
        .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_wd(bus.wb_wd), .data(byp2)
    );

    // Held operands pass through the same mux so a stalled EX entry sees writebacks.
    id_bypass_mux #(.XLEN(XLEN)) u_ref1 (
        .rs(bus.ex_rs1), .rf_data(bus.ex_op1),
        .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_wd(bus.wb_wd), .data(ref1)
    );

    id_bypass_mux #(.XLEN(XLEN)) u_ref2 (
        .rs(bus.ex_rs2), .rf_data(bus.ex_op2),
        .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_wd(bus.wb_wd), .data(ref2)
    );

    always_comb begin
        lu = bus.ex_valid && bus.ex_ctrl[MEMRD_BIT] && (bus.ex_rd != REG_ZERO) &&
             bus.id_valid && ((bus.id_rs1 == bus.ex_rd) || (bus.id_rs2 == bus.ex_rd));
        hold      = bus.ex_valid && !bus.ex_ready;
        bus.stall = !bus.flush && (lu || hold);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_pc      <= '0;
            bus.ex_imm     <= '0;
            bus.ex_rs1     <= '0;
            bus.ex_rs2     <= '0;
            bus.ex_rd      <= '0;
            bus.ex_op1     <= '0;
            bus.ex_op2     <= '0;
            bus.ex_ctrl    <= NOP_CTRL;
            bus.bubble_cnt <= '0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= NOP_CTRL;
        end else if (hold) begin
            bus.ex_op1 <= ref1;
            bus.ex_op2 <= ref2;
        end else if (lu) begin
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= NOP_CTRL;
            if (bus.bubble_cnt != '1) begin
                bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
            end
        end else begin
            bus.ex_valid <= bus.id_valid;
            bus.ex_pc    <= bus.id_pc;
            bus.ex_imm   <= bus.id_imm;
            bus.ex_rs1   <= bus.id_rs1;
            bus.ex_rs2   <= bus.id_rs2;
            bus.ex_rd    <= bus.id_rd;
            bus.ex_op1   <= byp1;
            bus.ex_op2   <= byp2;
            bus.ex_ctrl  <= bus.id_valid ? bus.id_ctrl : NOP_CTRL;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: issue, bypass, x0 guard,
// load-use bubble, hold refresh, flush priority and async reset.
module tb_id_ex_stage;
    import riscv_pipe_pkg::*;

    localparam logic [11:0] ALU_CTRL  = 12'(1 << REGWR_BIT);
    localparam logic [11:0] LOAD_CTRL = 12'((1 << REGWR_BIT) | (1 << MEMRD_BIT));

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    id_ex_stage_if #(.XLEN(32), .CTRL_W(12), .CNT_W(16)) bus ();

    id_ex_stage #(.XLEN(32), .CTRL_W(12), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [11:0] ctrl,
                                 input logic [31:0] rd1, input logic [31:0] rd2);
        bus.id_valid = v;
        bus.id_pc    = pc;
        bus.id_rs1   = rs1;
        bus.id_rs2   = rs2;
        bus.id_rd    = rd;
        bus.id_imm   = pc + 32'h4;
        bus.id_ctrl  = ctrl;
        bus.rf_rd1   = rd1;
        bus.rf_rd2   = rd2;
    endtask

    task automatic setWb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        bus.wb_we = we;
        bus.wb_rd = rd;
        bus.wb_wd = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.ex_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 12'h0, 32'h0, 32'h0);
        setWb(1'b0, 5'd0, 32'h0);
        #12;
        checkOutput("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("reset_ex_ctrl", 32'(bus.ex_ctrl), 32'(NOP_CTRL));
        checkOutput("reset_bubble_cnt", 32'(bus.bubble_cnt), 32'd0);
        checkOutput("reset_ex_op1", bus.ex_op1, 32'd0);
        checkOutput("reset_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;

        // Bubble input (id_valid=0) must load NOP control.
        applyStimulus(1'b0, 32'h40, 5'd1, 5'd2, 5'd3, ALU_CTRL, 32'h1, 32'h2);
        step();
        checkOutput("invalid_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("invalid_ex_ctrl", 32'(bus.ex_ctrl), 32'(NOP_CTRL));

        // Plain issue.
        applyStimulus(1'b1, 32'h100, 5'd3, 5'd4, 5'd6, ALU_CTRL, 32'h11, 32'h22);
        step();
        checkOutput("plain_ex_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("plain_ex_op1", bus.ex_op1, 32'h11);
        checkOutput("plain_ex_op2", bus.ex_op2, 32'h22);
        checkOutput("plain_ex_pc", bus.ex_pc, 32'h100);
        checkOutput("plain_ex_imm", bus.ex_imm, 32'h104);
        checkOutput("plain_ex_rd", 32'(bus.ex_rd), 32'd6);
        checkOutput("plain_ex_ctrl", 32'(bus.ex_ctrl), 32'(ALU_CTRL));
        checkOutput("plain_stall", 32'(bus.stall), 32'd0);

        // Same-cycle writeback bypass over stale RD1.
        setWb(1'b1, 5'd3, 32'hAB);
        applyStimulus(1'b1, 32'h104, 5'd3, 5'd4, 5'd6, ALU_CTRL, 32'h11, 32'h22);
        step();
        checkOutput("bypass_ex_op1", bus.ex_op1, 32'hAB);
        checkOutput("bypass_ex_op2", bus.ex_op2, 32'h22);

        // Writeback to x0 never bypasses; x0 reads zero.
        setWb(1'b1, 5'd0, 32'hFF);
        applyStimulus(1'b1, 32'h108, 5'd0, 5'd4, 5'd6, ALU_CTRL, 32'h77, 32'h22);
        step();
        checkOutput("x0_ex_op1", bus.ex_op1, 32'h0);
        setWb(1'b0, 5'd0, 32'h0);

        // Load-use: load x5 in EX, consumer reads rs2=5.
        applyStimulus(1'b1, 32'h10C, 5'd1, 5'd2, 5'd5, LOAD_CTRL, 32'h10, 32'h20);
        step();
        checkOutput("load_ex_ctrl", 32'(bus.ex_ctrl), 32'(LOAD_CTRL));
        applyStimulus(1'b1, 32'h110, 5'd8, 5'd5, 5'd9, ALU_CTRL, 32'h80, 32'h99);
        #1;
        checkOutput("lu_stall", 32'(bus.stall), 32'd1);
        step();
        checkOutput("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'(NOP_CTRL));
        checkOutput("lu_bubble_cnt", 32'(bus.bubble_cnt), 32'd1);
        checkOutput("lu_stall_released", 32'(bus.stall), 32'd0);
        setWb(1'b1, 5'd5, 32'h5A5A);
        step();
        checkOutput("lu_issue_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("lu_issue_op2", bus.ex_op2, 32'h5A5A);
        checkOutput("lu_issue_op1", bus.ex_op1, 32'h80);
        checkOutput("lu_issue_rd", 32'(bus.ex_rd), 32'd9);
        setWb(1'b0, 5'd0, 32'h0);

        // Hold with refresh of a held operand from writeback.
        applyStimulus(1'b1, 32'h114, 5'd7, 5'd2, 5'd10, ALU_CTRL, 32'h70, 32'h20);
        step();
        checkOutput("hold_load_op1", bus.ex_op1, 32'h70);
        bus.ex_ready = 1'b0;
        applyStimulus(1'b1, 32'h200, 5'd1, 5'd2, 5'd11, ALU_CTRL, 32'h1, 32'h2);
        #1;
        checkOutput("hold_stall_c0", 32'(bus.stall), 32'd1);
        step();
        checkOutput("hold_op1_c1", bus.ex_op1, 32'h70);
        checkOutput("hold_rd_c1", 32'(bus.ex_rd), 32'd10);
        checkOutput("hold_stall_c1", 32'(bus.stall), 32'd1);
        setWb(1'b1, 5'd7, 32'h55);
        step();
        checkOutput("hold_op1_c2", bus.ex_op1, 32'h55);
        checkOutput("hold_op2_c2", bus.ex_op2, 32'h20);
        setWb(1'b0, 5'd0, 32'h0);
        step();
        checkOutput("hold_op1_c3", bus.ex_op1, 32'h55);
        checkOutput("hold_pc_c3", bus.ex_pc, 32'h114);
        checkOutput("hold_valid_c3", 32'(bus.ex_valid), 32'd1);
        checkOutput("hold_stall_c3", 32'(bus.stall), 32'd1);
        bus.ex_ready = 1'b1;

        // Flush beats a load-use hazard.
        applyStimulus(1'b1, 32'h300, 5'd1, 5'd2, 5'd12, LOAD_CTRL, 32'h1, 32'h2);
        step();
        applyStimulus(1'b1, 32'h304, 5'd12, 5'd2, 5'd13, ALU_CTRL, 32'h1, 32'h2);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_stall", 32'(bus.stall), 32'd0);
        step();
        checkOutput("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("flush_ex_ctrl", 32'(bus.ex_ctrl), 32'(NOP_CTRL));
        checkOutput("flush_bubble_cnt", 32'(bus.bubble_cnt), 32'd1);
        bus.flush = 1'b0;

        // Async reset in the middle of a hold.
        applyStimulus(1'b1, 32'h400, 5'd1, 5'd2, 5'd14, ALU_CTRL, 32'h1, 32'h2);
        step();
        bus.ex_ready = 1'b0;
        #1;
        checkOutput("rst_hold_stall", 32'(bus.stall), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("rst_async_cnt", 32'(bus.bubble_cnt), 32'd0);
        checkOutput("rst_async_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        bus.ex_ready = 1'b1;
        step();
        checkOutput("post_rst_issue", 32'(bus.ex_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
